// File: rtl/bb_scrambler_ctrl_if.sv
// Bit-stream bundle around the scrambler controller:
// upstream valid/ready bits in, scrambled bits out.
interface bb_scrambler_ctrl_if;
    logic s_valid;
    logic s_bit;
    logic s_ready;
    logic m_valid;
    logic m_bit;
    logic m_last;

    modport slave (
        input  s_valid,
        input  s_bit,
        output s_ready,
        output m_valid,
        output m_bit,
        output m_last
    );

    modport master (
        output s_valid,
        output s_bit,
        input  s_ready,
        input  m_valid,
        input  m_bit,
        input  m_last
    );
endinterface

// File: rtl/bb_scrambler_ctrl.sv
// Frame sequencer for the BB scrambler: seeds the PRBS, feeds frame_len
// input bits, counts scrambled outputs and reports completion or timeout.
module bb_scrambler_ctrl #(
    parameter int unsigned LEN_W      = 16,
    parameter logic [14:0] INIT_STATE = 15'b100101010000000,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    output logic               busy,
    bb_scrambler_ctrl_if.slave sif,
    output logic [14:0]        scr_init_state,
    output logic               scr_load,
    output logic               scr_en,
    output logic               scr_in_bit,
    input  logic               scr_out_bit,
    input  logic               scr_out_en,
    output logic               done,
    output logic [1:0]         err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic live;
    logic xfer;
    logic cnt_out;
    logic last_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tmr_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            tmr_q     <= tmr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        tmr_d       = tmr_q;
        done_d      = 1'b0;
        err_d       = 2'b00;
        scr_load    = 1'b0;
        sif.s_ready = 1'b0;
        xfer        = 1'b0;

        live = (state_q != IDLE);

        // Only the first len outputs of a frame are counted; extras pass through
        cnt_out  = scr_out_en && (state_q == RUN || state_q == DRAIN)
                   && (out_cnt_q < len_q);
        last_out = cnt_out && (out_cnt_q == len_q - LEN_W'(1));
        if (cnt_out) begin
            out_cnt_d = out_cnt_q + LEN_W'(1);
        end

        if (start && live) begin
            err_d[0] = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len == '0) begin
                        err_d[0] = 1'b1;
                    end else begin
                        len_d     = frame_len;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                scr_load = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                sif.s_ready = (in_cnt_q < len_q);
                xfer        = sif.s_valid && sif.s_ready;
                if (xfer) begin
                    in_cnt_d = in_cnt_q + LEN_W'(1);
                    if (in_cnt_q == len_q - LEN_W'(1)) begin
                        tmr_d = TW'(1);
                        if (last_out) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (last_out || out_cnt_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q >= TW'(TIMEOUT - 1)) begin
                    err_d[1] = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = live;
    assign scr_init_state = INIT_STATE;
    assign scr_en         = xfer;
    assign scr_in_bit     = xfer && sif.s_bit;
    assign sif.m_valid    = live && scr_out_en;
    assign sif.m_bit      = live && scr_out_bit;
    assign sif.m_last     = last_out;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_bb_scrambler_ctrl.sv
// Bench for bb_scrambler_ctrl: behavioural scrambler stub with variable
// latency, frame table, random frames and hand-written corner sequences.
module tb_bb_scrambler_ctrl;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 64;
    localparam logic [14:0] SEED = 15'b100101010000000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic [14:0]      scr_init_state;
    logic             scr_load;
    logic             scr_en;
    logic             scr_in_bit;
    logic             scr_out_bit;
    logic             scr_out_en;
    logic             done;
    logic [1:0]       err;

    bb_scrambler_ctrl_if sif ();

    bb_scrambler_ctrl #(
        .LEN_W      (LEN_W),
        .INIT_STATE (SEED),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .frame_len      (frame_len),
        .busy           (busy),
        .sif            (sif),
        .scr_init_state (scr_init_state),
        .scr_load       (scr_load),
        .scr_en         (scr_en),
        .scr_in_bit     (scr_in_bit),
        .scr_out_bit    (scr_out_bit),
        .scr_out_en     (scr_out_en),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Scrambler stub: x^15+x^14+1, seeded from the DUT, latency lat_sel
    int          lat_sel = 1;
    int          wh_lim  = 1000;
    int          emitted = 0;
    logic [14:0] st      = '0;
    logic [3:0]  pv      = '0;
    logic [3:0]  pb      = '0;

    assign scr_out_en  = pv[lat_sel-1] && (emitted < wh_lim);
    assign scr_out_bit = pb[lat_sel-1];

    always @(posedge clk) begin
        pv <= {pv[2:0], scr_en};
        pb <= {pb[2:0], scr_in_bit ^ st[1] ^ st[0]};
        if (scr_out_en) emitted <= emitted + 1;
        if (scr_load) begin
            st      <= scr_init_state;
            emitted <= 0;
        end else if (scr_en) begin
            st <= {st[1] ^ st[0], st[14:1]};
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    bit bits[512];
    bit expo[512];
    bit prbs[512];

    // Reference PRBS from the seed, register index 1..15
    task automatic gen_prbs();
        int r[1:15];
        int fb;
        r = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 512; k++) begin
            fb = r[14] ^ r[15];
            prbs[k] = fb[0];
            for (int j = 15; j >= 2; j--) r[j] = r[j-1];
            r[1] = fb;
        end
    endtask

    typedef struct {
        int len;
        int vmode;
        int lat;
        int wh;
        bit inj;
        bit reuse;
        bit exp_done;
        int exp_outs;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int cyc = 0, acc = 0, oc = 0, loads = 0, load_cyc = -1;
        int dones = 0, e0 = 0, e1 = 0, ens = 0;
        int last_acc = -1, last_ml = -100, budget;
        int bad_en = 0, bad_bit = 0, bad_mb = 0, bad_ml = 0, bad_busy = 0;
        bit fin = 0;
        if (!v.reuse) begin
            for (int i = 0; i < v.len; i++) bits[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < v.len; i++) expo[i] = bits[i] ^ prbs[i];
        lat_sel = v.lat;
        wh_lim  = v.wh;
        budget  = 4 * v.len + TIMEOUT + 20;
        @(posedge clk); #1;
        start       = 1'b1;
        frame_len   = LEN_W'(v.len);
        sif.s_valid = 1'b0;
        sif.s_bit   = 1'b0;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            if (scr_load) begin
                loads++;
                load_cyc = cyc;
            end
            if (cyc == 1 && sif.s_ready) bad_en++;
            if (sif.s_valid && sif.s_ready) begin
                if (!scr_en || scr_in_bit != bits[acc]) bad_bit++;
                acc++;
                last_acc = cyc;
            end else if (scr_en) begin
                bad_en++;
            end
            if (scr_en) ens++;
            if (sif.m_valid) begin
                if (oc < v.len) begin
                    if (sif.m_bit != expo[oc]) bad_mb++;
                    if (sif.m_last != (oc == v.len - 1)) bad_ml++;
                    if (sif.m_last) last_ml = cyc;
                end else if (sif.m_last) begin
                    bad_ml++;
                end
                oc++;
            end else if (sif.m_last) begin
                bad_ml++;
            end
            if (err[0]) e0++;
            if (done) begin
                dones++;
                check("done_after_last", cyc - last_ml, 1);
                check("busy_at_done", int'(busy), 0);
                fin = 1;
            end
            if (err[1]) begin
                e1++;
                check("timeout_cycles", cyc - last_acc, TIMEOUT);
                check("busy_at_timeout", int'(busy), 0);
                fin = 1;
            end
            if (!fin && cyc >= 1 && !busy) bad_busy++;
            cyc++;
            if (!fin) begin
                @(posedge clk); #1;
                start = v.inj && cyc == 5;
                if (v.inj) frame_len = LEN_W'(3);
                unique case (v.vmode)
                    0: sif.s_valid = 1'b1;
                    1: sif.s_valid = (cyc % 2 == 0);
                    default: sif.s_valid = ($urandom_range(0, 3) != 0);
                endcase
                sif.s_bit = (acc < v.len) ? bits[acc] : 1'($urandom_range(0, 1));
            end
        end
        start       = 1'b0;
        sif.s_valid = 1'b0;
        check("frame_ended", int'(fin), 1);
        check("load_count", loads, 1);
        check("load_cycle", load_cyc, 1);
        check("scr_en_count", ens, v.len);
        check("inputs_taken", acc, v.len);
        check("outputs_seen", oc, v.exp_outs);
        check("done_count", dones, int'(v.exp_done));
        check("timeout_count", e1, int'(!v.exp_done));
        check("start_err_count", e0, int'(v.inj));
        check("bad_scr_en", bad_en, 0);
        check("bad_in_bit", bad_bit, 0);
        check("bad_m_bit", bad_mb, 0);
        check("bad_m_last", bad_ml, 0);
        check("busy_dropped", bad_busy, 0);
        if (v.vmode == 0) check("last_input_cycle", last_acc, v.len + 1);
        if (v.vmode == 1) check("last_input_cycle", last_acc, 2 * v.len);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t rv;
        vecs[0] = '{8,  0, 1, 1000, 0, 0, 1, 8};
        vecs[1] = '{16, 1, 1, 1000, 0, 0, 1, 16};
        vecs[2] = '{12, 0, 1, 1000, 0, 0, 1, 12};
        vecs[3] = '{12, 0, 1, 1000, 0, 1, 1, 12};
        vecs[4] = '{20, 0, 2, 1000, 1, 0, 1, 20};
        vecs[5] = '{10, 0, 1, 5,    0, 0, 0, 5};
        vecs[6] = '{1,  0, 1, 1000, 0, 0, 1, 1};
        vecs[7] = '{1,  1, 3, 1000, 0, 0, 1, 1};
        vecs[8] = '{30, 2, 3, 1000, 0, 0, 1, 30};
        vecs[9] = '{25, 2, 2, 1000, 0, 0, 1, 25};
        gen_prbs();

        reset       = 1'b1;
        start       = 1'b0;
        frame_len   = '0;
        sif.s_valid = 1'b0;
        sif.s_bit   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({busy, sif.s_ready, scr_en, scr_in_bit, scr_load,
                    sif.m_valid, sif.m_bit, sif.m_last, done, err}), 0);
        check("reset_seed", int'(scr_init_state), int'(SEED));
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-length start is rejected without leaving IDLE
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_len_err", int'(err), 1);
        check("zero_len_busy", int'(busy), 0);
        @(negedge clk);
        check("zero_len_err_clear", int'(err), 0);
        check("zero_len_no_load", int'(scr_load), 0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            rv.len      = $urandom_range(1, 40);
            rv.vmode    = 2;
            rv.lat      = $urandom_range(1, 3);
            rv.wh       = 1000;
            rv.inj      = 0;
            rv.reuse    = 0;
            rv.exp_done = 1;
            rv.exp_outs = rv.len;
            run_frame(rv);
        end

        // Reset in RUN after three of twenty bits
        lat_sel = 1;
        wh_lim  = 1000;
        @(posedge clk); #1;
        start     = 1'b1;
        frame_len = LEN_W'(20);
        @(posedge clk); #1;
        start       = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_bit   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_run_busy", int'(busy), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_run_reset_outputs",
              int'({busy, sif.s_ready, scr_en, scr_in_bit, scr_load,
                    sif.m_valid, sif.m_bit, sif.m_last, done, err}), 0);
        sif.s_valid = 1'b0;
        rv = '{4, 0, 1, 1000, 0, 0, 1, 4};
        run_frame(rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
